// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid, stall/flush handling,
// sticky illegal-stall detection and saturating bubble/hold counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VAL   = '0,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       STAGE_IDX = 4,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic               stall_err
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              sp, sn, illegal;
  act_e              act;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              stall_err_q, stall_err_d;

  assign sp      = stall[STAGE_IDX];
  assign sn      = stall[STAGE_IDX+1];
  assign illegal = !sp && sn;

  // Consumer stalled (legal or not) means hold so unconsumed data is never overwritten.
  always_comb begin
    act = ACT_CAPTURE;
    if (flush)          act = ACT_FLUSH;
    else if (sp && !sn) act = ACT_BUBBLE;
    else if (sn)        act = ACT_HOLD;
  end

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    stall_err_d  = stall_err_q | illegal;

    unique case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_VAL;
      end
      ACT_CAPTURE: begin
        valid_d = in_valid;
        data_d  = in_valid ? in_data : NOP_VAL;
      end
      default: ;
    endcase

    if (act == ACT_BUBBLE && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    if (act == ACT_HOLD && hold_cnt_q != CNT_MAX)
      hold_cnt_d = hold_cnt_q + CNT_W'(1);

    if (cnt_clr) begin
      bubble_cnt_d = '0;
      hold_cnt_d   = '0;
      stall_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      data_q       <= NOP_VAL;
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
  assign stall_err  = stall_err_q;

endmodule
